rv32i_accel_issue_queue: RTL

Decoupling stage between the RV32I core's execute stage and `rv32i_rtype_accel_top`. It buffers custom R-type accelerator instructions with operand values in a small FIFO and issues them over the accelerator's valid/ready port. It also registers accelerator register writebacks back to the core. An optional scoreboard tracks destination registers with an outstanding writeback and raises a RAW hazard stall to the core.

---
 rtl/accel_iq_pkg.sv | 22 ++
 rtl/rv32i_accel_issue_queue_if.sv | 25 ++
 rtl/accel_iq_fifo.sv | 72 +++++++
 rtl/rv32i_accel_issue_queue.sv | 123 ++++++++++++
 4 files changed

// File: rtl/accel_iq_pkg.sv
// Shared types for the RV32I accelerator issue queue: the FIFO entry layout
// and the architectural register count.
package accel_iq_pkg;

   localparam int REG_CNT = 32;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
   } iq_entry_t;

   // One-hot mask selecting a single architectural register.
   function automatic logic [REG_CNT-1:0] reg_onehot(input logic [4:0] addr);
      logic [REG_CNT-1:0] mask;
      mask       = {REG_CNT{1'b0}};
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/rv32i_accel_issue_queue_if.sv
// Accelerator-side bus of the issue queue: instruction issue (valid/ready)
// and the writeback coming back from the accelerator.
interface rv32i_accel_issue_queue_if;

   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd_addr;
   logic        rd_we;
   logic [4:0]  rd_waddr;
   logic [31:0] rd_wdata;

   modport master (
      output instr_valid, instr, rs1_val, rs2_val, rd_addr,
      input  instr_ready, rd_we, rd_waddr, rd_wdata
   );

   modport slave (
      input  instr_valid, instr, rs1_val, rs2_val, rd_addr,
      output instr_ready, rd_we, rd_waddr, rd_wdata
   );

endinterface

// File: rtl/accel_iq_fifo.sv
// Generic DEPTH-entry valid/ready FIFO of iq_entry_t with occupancy output.
// DEPTH must be a power of two so the pointers wrap naturally.
module accel_iq_fifo
   import accel_iq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  iq_entry_t        in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output iq_entry_t        out_data,
   output logic [CNT_W-1:0] count
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

   iq_entry_t        mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_s;
   logic             pop_s;

   assign in_ready  = (count_r != FULL_CNT);
   assign out_valid = (count_r != ZERO_CNT);
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;
   assign count     = count_r;

   // Head is stable while waiting; an empty queue shows entry 0.
   assign out_data  = out_valid ? mem_r[rd_ptr_r] : mem_r[0];

   // Entry storage, written at the tail on every accepted push.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '{instr: 32'd0, rs1: 32'd0, rs2: 32'd0, rd: 5'd0};
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= ZERO_CNT;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/rv32i_accel_issue_queue.sv
// Issue queue between the RV32I execute stage and the R-type accelerator,
// plus registered writeback. Optional RAW/WAW scoreboard: ACCEL_IQ_SCOREBOARD_EN.
module rv32i_accel_issue_queue
   import accel_iq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        core_valid,
   output logic                        core_ready,
   input  logic [31:0]                 core_instr,
   input  logic [31:0]                 core_rs1_val,
   input  logic [31:0]                 core_rs2_val,
   input  logic [4:0]                  core_rd_addr,
   input  logic [4:0]                  hz_rs1_addr,
   input  logic [4:0]                  hz_rs2_addr,
   output logic                        hz_stall,
   rv32i_accel_issue_queue_if.master   acc,
   output logic                        wb_we,
   output logic [4:0]                  wb_waddr,
   output logic [31:0]                 wb_wdata,
   output logic [CNT_W-1:0]            iq_count,
   output logic                        sb_err
);

   iq_entry_t in_entry_s;
   iq_entry_t head_s;
   logic      fifo_ready_s;
   logic      waw_s;
   logic      enq_s;

   assign in_entry_s = '{instr: core_instr, rs1: core_rs1_val,
                         rs2: core_rs2_val, rd: core_rd_addr};

   // A full queue refuses even if it is draining this cycle.
   assign core_ready = fifo_ready_s && !waw_s;
   assign enq_s      = core_valid && core_ready;

   accel_iq_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (core_valid && !waw_s),
      .in_ready  (fifo_ready_s),
      .in_data   (in_entry_s),
      .out_valid (acc.instr_valid),
      .out_ready (acc.instr_ready),
      .out_data  (head_s),
      .count     (iq_count)
   );

   assign acc.instr   = head_s.instr;
   assign acc.rs1_val = head_s.rs1;
   assign acc.rs2_val = head_s.rs2;
   assign acc.rd_addr = head_s.rd;

   // Writeback register toward the core register file; x0 writes are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_we    <= 1'b0;
         wb_waddr <= 5'd0;
         wb_wdata <= 32'd0;
      end else begin
         wb_we <= acc.rd_we && (acc.rd_waddr != 5'd0);
         if (acc.rd_we) begin
            wb_waddr <= acc.rd_waddr;
            wb_wdata <= acc.rd_wdata;
         end
      end
   end

`ifdef ACCEL_IQ_SCOREBOARD_EN
   logic [REG_CNT-1:0] pending_r;
   logic [REG_CNT-1:0] set_s;
   logic [REG_CNT-1:0] clr_s;

   assign waw_s    = (core_rd_addr != 5'd0) && pending_r[core_rd_addr];
   assign hz_stall = ((hz_rs1_addr != 5'd0) && pending_r[hz_rs1_addr]) ||
                     ((hz_rs2_addr != 5'd0) && pending_r[hz_rs2_addr]);

   // Per-cycle set/clear masks for the pending registers.
   always_comb begin
      set_s = {REG_CNT{1'b0}};
      clr_s = {REG_CNT{1'b0}};
      if (enq_s && (core_rd_addr != 5'd0)) begin
         set_s = reg_onehot(core_rd_addr);
      end else begin
         set_s = {REG_CNT{1'b0}};
      end
      if (wb_we) begin
         clr_s = reg_onehot(wb_waddr);
      end else begin
         clr_s = {REG_CNT{1'b0}};
      end
   end

   // Pending mask (set wins over clear) and sticky unexpected-writeback error.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r <= {REG_CNT{1'b0}};
         sb_err    <= 1'b0;
      end else begin
         pending_r <= (pending_r & ~clr_s) | set_s;
         if (wb_we && !pending_r[wb_waddr]) begin
            sb_err <= 1'b1;
         end
      end
   end
`else
   logic unused_hz_s;

   // Without the scoreboard software serialises hazards.
   assign unused_hz_s = ^{hz_rs1_addr, hz_rs2_addr, enq_s};
   assign waw_s       = 1'b0;
   assign hz_stall    = 1'b0;
   assign sb_err      = 1'b0;
`endif

endmodule
